jk_drive_seq: RTL and testbench

Synthesizable driver that sits on the input side of a JK flip-flop and steers it to a requested bit sequence. It accepts target bits over a valid/ready handshake, computes the JK excitation from the flip-flop's fed-back `q`, drives `j`/`k` for exactly one clock, then checks that `q` reached the target. It replaces hand-written j/k stimulus and enables in-circuit self-checking of JK storage elements.

---
 rtl/jk_drive_seq.sv | 107 ++++++++++
 tb/tb_jk_drive_seq.sv | 277 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/jk_drive_seq.sv
// jk_drive_seq: steers an external JK flip-flop (clocked by the same clk) to a
// requested bit. Each accepted target bit gets one cycle of j/k excitation
// computed from the fed-back q, then one check cycle in which q_fb is compared
// with the target.
// Optional feature: define JK_DRV_ERRCNT_EN to build the saturating mismatch
// counter behind err_cnt. Without it, err_cnt is tied to zero.
module jk_drive_seq #(
  parameter int CNT_W      = 8,
  parameter bit USE_TOGGLE = 1'b0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             in_bit,
  input  logic             q_fb,
  output logic             j,
  output logic             k,
  output logic             done,
  output logic             err,
  output logic [CNT_W-1:0] err_cnt
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    DRIVE = 2'd1,
    CHECK = 2'd2
  } state_t;

  state_t state_reg, state_next;
  logic   tgt_reg, tgt_next;
  logic   j_reg, j_next;
  logic   k_reg, k_next;

  // State, latched target and the j/k output flops.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg <= IDLE;
      tgt_reg   <= 1'b0;
      j_reg     <= 1'b0;
      k_reg     <= 1'b0;
    end else begin
      state_reg <= state_next;
      tgt_reg   <= tgt_next;
      j_reg     <= j_next;
      k_reg     <= k_next;
    end
  end

  // Next-state logic. The excitation code is decided at the accept edge so
  // that j/k are already stable for the whole DRIVE cycle; every other cycle
  // presents the hold code 00.
  always_comb begin
    state_next = state_reg;
    tgt_next   = tgt_reg;
    j_next     = 1'b0;
    k_next     = 1'b0;
    case (state_reg)
      IDLE: begin
        if (in_valid) begin
          tgt_next   = in_bit;
          state_next = DRIVE;
          // A change is needed only when q differs from the target; a match
          // always holds with 00 so a toggle can never flip a correct bit.
          if (q_fb != in_bit) begin
            if (USE_TOGGLE) begin
              j_next = 1'b1;
              k_next = 1'b1;
            end else begin
              j_next = in_bit;
              k_next = ~in_bit;
            end
          end
        end
      end
      DRIVE:   state_next = CHECK;
      CHECK:   state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  assign j        = j_reg;
  assign k        = k_reg;
  assign in_ready = (state_reg == IDLE);
  // The flip-flop has captured j/k at the start of CHECK, so q_fb already
  // shows the result during this cycle.
  assign done     = (state_reg == CHECK);
  assign err      = done & (q_fb ^ tgt_reg);

`ifdef JK_DRV_ERRCNT_EN
  logic [CNT_W-1:0] err_cnt_reg;

  // Saturating count of mismatches; cleared only by reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      err_cnt_reg <= '0;
    end else if (err && (err_cnt_reg != {CNT_W{1'b1}})) begin
      err_cnt_reg <= err_cnt_reg + CNT_W'(1);
    end
  end

  assign err_cnt = err_cnt_reg;
`else
  assign err_cnt = '0;
`endif

endmodule

// File: tb/tb_jk_drive_seq.sv
// Bench for jk_drive_seq. Three instances share one stimulus stream:
// u_dut0 (set/reset codes, 8-bit counter), u_dut1 (toggle codes) and
// u_dut2 (2-bit counter for saturation). Each drives its own JK flip-flop.
module tb_jk_drive_seq;

`ifdef JK_DRV_ERRCNT_EN
  localparam bit CNT_EN = 1'b1;
`else
  localparam bit CNT_EN = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst, in_valid, in_bit;
  logic stuck, ff_clr;
  logic q0, q1, q2;
  logic qf0, qf1, qf2;
  logic rdy0, rdy1, rdy2;
  logic j0, k0, j1, k1, j2, k2;
  logic done0, done1, done2;
  logic err0, err1, err2;
  logic [7:0] cnt0, cnt1;
  logic [1:0] cnt2;

  int checks = 0;
  int errors = 0;
  logic model_q;          // value the healthy flip-flop should hold
  int unsigned total_err; // mismatching transfers since last driver reset

  always #5 clk = ~clk;

  jk_drive_seq #(.CNT_W(8), .USE_TOGGLE(1'b0)) u_dut0 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(rdy0), .in_bit(in_bit),
    .q_fb(qf0), .j(j0), .k(k0), .done(done0), .err(err0), .err_cnt(cnt0));
  jk_drive_seq #(.CNT_W(8), .USE_TOGGLE(1'b1)) u_dut1 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(rdy1), .in_bit(in_bit),
    .q_fb(qf1), .j(j1), .k(k1), .done(done1), .err(err1), .err_cnt(cnt1));
  jk_drive_seq #(.CNT_W(2), .USE_TOGGLE(1'b0)) u_dut2 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(rdy2), .in_bit(in_bit),
    .q_fb(qf2), .j(j2), .k(k2), .done(done2), .err(err2), .err_cnt(cnt2));

  // Behavioural JK flip-flops; 'stuck' forces the observed q to 0.
  function automatic logic jk_ff(input logic q, input logic jj, input logic kk);
    case ({jj, kk})
      2'b01:   return 1'b0;
      2'b10:   return 1'b1;
      2'b11:   return ~q;
      default: return q;
    endcase
  endfunction

  always @(posedge clk) begin
    if (ff_clr) begin
      q0 <= 1'b0; q1 <= 1'b0; q2 <= 1'b0;
    end else begin
      q0 <= jk_ff(q0, j0, k0);
      q1 <= jk_ff(q1, j1, k1);
      q2 <= jk_ff(q2, j2, k2);
    end
  end
  assign qf0 = stuck ? 1'b0 : q0;
  assign qf1 = stuck ? 1'b0 : q1;
  assign qf2 = stuck ? 1'b0 : q2;

  // Excitation table: hold when already there, else set/reset or toggle.
  function automatic logic [1:0] exp_code(input logic cur, input logic tgt, input bit tog);
    if (cur == tgt) return 2'b00;
    if (tog) return 2'b11;
    return tgt ? 2'b10 : 2'b01;
  endfunction

  function automatic int unsigned sat(input int unsigned v, input int unsigned lim);
    return (v > lim) ? lim : v;
  endfunction

  function automatic logic [7:0] exp_cnt8();
    return CNT_EN ? 8'(sat(total_err, 255)) : 8'd0;
  endfunction

  function automatic logic [1:0] exp_cnt2();
    return CNT_EN ? 2'(sat(total_err, 3)) : 2'd0;
  endfunction

  // One transfer starting from IDLE; returns one cycle after CHECK (idle again).
  task automatic send_bit(input logic b);
    logic cur;
    logic exp_err;
    logic [1:0] e0, e1;
    cur = stuck ? 1'b0 : model_q;
    e0 = exp_code(cur, b, 1'b0);
    e1 = exp_code(cur, b, 1'b1);
    checks++;
    if (rdy0 !== 1'b1) begin errors++; $display("FAIL ready_before_accept: got %b want 1", rdy0); end
    in_valid = 1'b1; in_bit = b;
    @(posedge clk); #1;
    in_valid = 1'b0; in_bit = 1'($urandom);
    // DRIVE cycle
    checks++;
    if ({j0, k0} !== e0) begin errors++; $display("FAIL drive_code_setreset: got %b%b want %b", j0, k0, e0); end
    checks++;
    if ({j1, k1} !== e1) begin errors++; $display("FAIL drive_code_toggle: got %b%b want %b", j1, k1, e1); end
    checks++;
    if (rdy0 !== 1'b0 || done0 !== 1'b0) begin
      errors++; $display("FAIL drive_flags: ready=%b done=%b want ready=0 done=0", rdy0, done0);
    end
    @(posedge clk); #1;
    // CHECK cycle
    exp_err = stuck ? (b != 1'b0) : 1'b0;
    if (exp_err) total_err++;
    if (!stuck) model_q = b;
    checks++;
    if (done0 !== 1'b1 || done1 !== 1'b1) begin
      errors++; $display("FAIL check_done: got %b/%b want 1/1", done0, done1);
    end
    checks++;
    if (err0 !== exp_err || err2 !== exp_err) begin
      errors++; $display("FAIL check_err: got %b/%b want %b", err0, err2, exp_err);
    end
    checks++;
    if ({j0, k0, j1, k1} !== 4'b0000 || rdy0 !== 1'b0) begin
      errors++; $display("FAIL check_hold: jk=%b%b ready=%b want jk=00 ready=0", j0, k0, rdy0);
    end
    if (!stuck) begin
      checks++;
      if (qf0 !== b || qf1 !== b) begin errors++; $display("FAIL q_reached: got %b/%b want %b", qf0, qf1, b); end
    end
    $display("xfer tgt=%0d code=%b%b tcode=%b%b done=%0d err=%0d", b, e0[1], e0[0], e1[1], e1[0], done0, err0);
    @(posedge clk); #1;
    // back in IDLE, counter updated
    checks++;
    if (rdy0 !== 1'b1 || done0 !== 1'b0 || err0 !== 1'b0) begin
      errors++; $display("FAIL return_idle: ready=%b done=%b err=%b want 1/0/0", rdy0, done0, err0);
    end
    checks++;
    if (cnt0 !== exp_cnt8() || cnt2 !== exp_cnt2()) begin
      errors++; $display("FAIL err_cnt: got %0d/%0d want %0d/%0d", cnt0, cnt2, exp_cnt8(), exp_cnt2());
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; in_valid = 1'b1; in_bit = 1'b1; ff_clr = 1'b1; stuck = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    // reset wins over a simultaneous accept
    checks++;
    if ({j0, k0} !== 2'b00 || done0 !== 1'b0 || err0 !== 1'b0 || rdy0 !== 1'b1 || cnt0 !== 8'd0) begin
      errors++; $display("FAIL reset_state: jk=%b%b done=%b err=%b ready=%b cnt=%0d", j0, k0, done0, err0, rdy0, cnt0);
    end
    rst = 1'b0; in_valid = 1'b0; ff_clr = 1'b0;
    model_q = 1'b0; total_err = 0;
    @(posedge clk); #1;
    // start a transfer, then reset during DRIVE
    in_valid = 1'b1; in_bit = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    checks++;
    if ({j0, k0} !== 2'b10) begin errors++; $display("FAIL abort_drive_code: got %b%b want 10", j0, k0); end
    rst = 1'b1;
    @(posedge clk); #1;
    model_q = 1'b1; // the flip-flop still captured the set code
    checks++;
    if ({j0, k0} !== 2'b00 || done0 !== 1'b0 || rdy0 !== 1'b1 || cnt0 !== 8'd0) begin
      errors++; $display("FAIL reset_mid_drive: jk=%b%b done=%b ready=%b cnt=%0d", j0, k0, done0, rdy0, cnt0);
    end
    @(posedge clk); #1;
    rst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      checks++;
      if (done0 !== 1'b0 || err0 !== 1'b0) begin
        errors++; $display("FAIL aborted_no_done: cycle %0d done=%b err=%b want 0", i, done0, err0);
      end
    end
    checks++;
    if (qf0 !== model_q) begin errors++; $display("FAIL ff_not_reset_by_driver: got %b want %b", qf0, model_q); end
    ff_clr = 1'b1;
    @(posedge clk); #1;
    ff_clr = 1'b0; model_q = 1'b0;
  endtask

  task automatic test_excitation_sweep();
    logic [3:0] seq;
    seq = 4'b1100; // sent MSB first: 1,1,0,0
    for (int i = 3; i >= 0; i--) send_bit(seq[i]);
  endtask

  task automatic test_random();
    int gap;
    for (int n = 0; n < 24; n++) begin
      gap = int'($urandom_range(0, 2));
      for (int g = 0; g < gap; g++) begin
        @(posedge clk); #1;
        checks++;
        if (done0 !== 1'b0 || rdy0 !== 1'b1) begin
          errors++; $display("FAIL idle_gap: done=%b ready=%b want 0/1", done0, rdy0);
        end
      end
      send_bit(1'($urandom_range(0, 1)));
    end
  endtask

  // Valid held high with in_bit changing every cycle: only idle-cycle bits
  // are taken, and the driver stays busy for the DRIVE and CHECK cycles.
  task automatic test_back_to_back();
    logic q_tgt[$];
    int busy;
    logic acc;
    logic want;
    busy = 0;
    in_bit = 1'($urandom);
    for (int i = 0; i < 20; i++) begin
      in_valid = (i < 17);
      in_bit = ~in_bit;
      checks++;
      if (rdy0 !== (busy == 0)) begin
        errors++; $display("FAIL hs_ready: cycle %0d got %b want %b", i, rdy0, (busy == 0));
      end
      acc = in_valid && (busy == 0);
      if (acc) q_tgt.push_back(in_bit);
      @(posedge clk); #1;
      if (acc) busy = 2; else if (busy > 0) busy--;
      checks++;
      if (done0 !== (busy == 1)) begin
        errors++; $display("FAIL hs_done: cycle %0d got %b want %b", i, done0, (busy == 1));
      end
      if (busy == 1 && q_tgt.size() > 0) begin
        want = q_tgt.pop_front();
        model_q = want;
        checks++;
        if (qf0 !== want || err0 !== 1'b0) begin
          errors++; $display("FAIL hs_captured: got q=%b err=%b want q=%b err=0", qf0, err0, want);
        end
        $display("xfer handshake tgt=%0d q=%0d", want, qf0);
      end
    end
    in_valid = 1'b0;
  endtask

  task automatic test_fault();
    stuck = 1'b1;
    for (int i = 0; i < 3; i++) send_bit(1'b1);
    checks++;
    if (cnt0 !== (CNT_EN ? 8'd3 : 8'd0)) begin
      errors++; $display("FAIL fault_count: got %0d want %0d", cnt0, (CNT_EN ? 3 : 0));
    end
  endtask

  task automatic test_saturation();
    for (int i = 0; i < 2; i++) send_bit(1'b1);
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if (cnt2 !== (CNT_EN ? 2'd3 : 2'd0) || cnt0 !== (CNT_EN ? 8'd5 : 8'd0)) begin
      errors++; $display("FAIL saturation: got %0d/%0d want %0d/%0d", cnt2, cnt0,
                         (CNT_EN ? 3 : 0), (CNT_EN ? 5 : 0));
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; in_valid = 1'b0; in_bit = 1'b0; stuck = 1'b0; ff_clr = 1'b1;
    model_q = 1'b0; total_err = 0;
    test_reset();
    test_excitation_sweep();
    test_random();
    test_back_to_back();
    test_fault();
    test_saturation();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
